// File: rtl/vec_mod_sub_if.sv
// rtl/vec_mod_sub_if.sv - request/result bundle for vec_mod_sub (range_err present with VEC_MOD_SUB_RANGE_CHECK_EN)
interface vec_mod_sub_if #(
    parameter int BIT_WIDTH = 64,
    parameter int LANES     = 4
);
    logic                         start;
    logic                         mode;
    logic [BIT_WIDTH-1:0]         q;
    logic [LANES*BIT_WIDTH-1:0]   a;
    logic [LANES*BIT_WIDTH-1:0]   b;
    logic [LANES*BIT_WIDTH-1:0]   c;
    logic                         busy;
    logic                         done;
`ifdef VEC_MOD_SUB_RANGE_CHECK_EN
    logic                         range_err;

    modport master (output start, mode, q, a, b, input c, busy, done, range_err);
    modport slave  (input start, mode, q, a, b, output c, busy, done, range_err);
`else
    modport master (output start, mode, q, a, b, input c, busy, done);
    modport slave  (input start, mode, q, a, b, output c, busy, done);
`endif
endinterface

// File: rtl/vec_mod_sub.sv
// rtl/vec_mod_sub.sv - lane-serial vector modular add/subtract; optional range check via VEC_MOD_SUB_RANGE_CHECK_EN
module vec_mod_sub #(
    parameter int BIT_WIDTH = 64,
    parameter int LANES     = 4
) (
    input  logic         clk,
    input  logic         rst,
    vec_mod_sub_if.slave bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VW = LANES * BIT_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [VW-1:0]        a_q, a_d, b_q, b_d;
    logic [VW-1:0]        res_q, res_d, c_q, c_d;
    logic [BIT_WIDTH-1:0] q_q, q_d;
    logic                 mode_q, mode_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [BIT_WIDTH-1:0] op_a, op_b, lane_res;
    logic [BIT_WIDTH:0]   sum, diff;

`ifdef VEC_MOD_SUB_RANGE_CHECK_EN
    logic                 err_q, err_d;
    logic                 range_err_q, range_err_d;
    logic                 lane_err;
`endif

    // Shared datapath: one lane per cycle, selected by the lane counter
    always_comb begin
        op_a = a_q[lane_q*BIT_WIDTH +: BIT_WIDTH];
        op_b = b_q[lane_q*BIT_WIDTH +: BIT_WIDTH];
        sum  = {1'b0, op_a} + {1'b0, op_b};
        diff = {1'b0, op_a} - {1'b0, op_b};
        if (mode_q) begin
            lane_res = (sum >= {1'b0, q_q}) ? (sum[BIT_WIDTH-1:0] - q_q) : sum[BIT_WIDTH-1:0];
        end else begin
            lane_res = diff[BIT_WIDTH] ? (diff[BIT_WIDTH-1:0] + q_q) : diff[BIT_WIDTH-1:0];
        end
`ifdef VEC_MOD_SUB_RANGE_CHECK_EN
        lane_err = (op_a >= q_q) || (op_b >= q_q) || (q_q == '0);
`endif
    end

    // Control FSM: capture on accept, walk lanes, publish all lanes at once
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        mode_d  = mode_q;
        res_d   = res_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef VEC_MOD_SUB_RANGE_CHECK_EN
        err_d       = err_q;
        range_err_d = range_err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = BUSY;
                    lane_d  = '0;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    q_d     = bus.q;
                    mode_d  = bus.mode;
                    busy_d  = 1'b1;
`ifdef VEC_MOD_SUB_RANGE_CHECK_EN
                    err_d   = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                res_d[lane_q*BIT_WIDTH +: BIT_WIDTH] = lane_res;
`ifdef VEC_MOD_SUB_RANGE_CHECK_EN
                err_d = err_q | lane_err;
`endif
                if (lane_q == LW'(LANES - 1)) begin
                    state_d = DONE;
                    lane_d  = '0;
                    c_d     = res_d;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef VEC_MOD_SUB_RANGE_CHECK_EN
                    range_err_d = err_q | lane_err;
`endif
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            mode_q  <= 1'b0;
            res_q   <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef VEC_MOD_SUB_RANGE_CHECK_EN
            err_q       <= 1'b0;
            range_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef VEC_MOD_SUB_RANGE_CHECK_EN
            err_q       <= err_d;
            range_err_q <= range_err_d;
`endif
        end
    end

    assign bus.c    = c_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef VEC_MOD_SUB_RANGE_CHECK_EN
    assign bus.range_err = range_err_q;
`endif
endmodule
